// File: rtl/heap_pkg.sv
// Shared definitions for the heapsort root controller and its clear sequencer.
package heap_pkg;

    typedef enum logic [3:0] {
        CLEAR,
        CLR_ROOT,
        INIT,
        IDLE,
        RD0,
        RD1,
        RD2,
        EMIT,
        HOLD
    } state_t;

    // Root memory read latency: registered address plus registered output.
    localparam int RAM_LAT = 2;

    // Wide all-ones pattern; modules slice it down to WIDTH+1 bits for the sentinel.
    localparam logic [63:0] SENTINEL_BITS = '1;

endpackage

// File: rtl/heap_clear_seq.sv
// Walks every level-memory address once, broadcasting a write of the sentinel.
module heap_clear_seq #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] clr_addr,
    output logic          clr_wren,
    output logic          done
);

    logic [AW-1:0] cnt;

    // done is seen by the owner FSM in the same cycle the last address is issued.
    assign done = en && (cnt == {AW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            clr_addr <= '0;
            clr_wren <= 1'b0;
        end else if (en) begin
            clr_wren <= 1'b1;
            clr_addr <= cnt;
            cnt      <= cnt + AW'(1);
        end else begin
            clr_wren <= 1'b0;
        end
    end

endmodule

// File: rtl/heap_root_ctrl.sv
// Root-side initiator of the pipelined heapsort chain: clears all level memories,
// starts the sorting nodes, then performs replace-top operations on the root record.
module heap_root_ctrl
    import heap_pkg::*;
#(
    parameter int WIDTH      = 15,
    parameter int LEVELS     = 3,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH:0]    in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH:0]    out_data,
    output logic              out_sentinel,
    input  logic [WIDTH:0]    q_U,
    output logic [WIDTH:0]    data_U,
    output logic              addr_U,
    output logic              wren_U,
    output logic [LEVELS-2:0] clr_addr,
    output logic [WIDTH:0]    clr_data,
    output logic              clr_wren,
    output logic              initialize,
    output logic              update_out,
    output logic [LEVELS-2:0] address_updated_out
);

    localparam logic [WIDTH:0] SENTINEL = SENTINEL_BITS[WIDTH:0];
    localparam int             GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic [WIDTH:0] new_reg;
    logic [WIDTH:0] old_reg;
    logic           clr_en;
    logic           clr_done;
    logic           accept;

    assign clr_en              = (state == CLEAR);
    assign accept              = (state == IDLE) && in_valid && in_ready;
    assign clr_data            = SENTINEL;
    assign addr_U              = 1'b0;
    assign address_updated_out = '0;

    heap_clear_seq #(
        .AW (LEVELS - 1)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (clr_en),
        .clr_addr (clr_addr),
        .clr_wren (clr_wren),
        .done     (clr_done)
    );

    // Key and popped-value holding registers carry no reset; the FSM qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            new_reg <= in_data;
        end
        if (state == RD2) begin
            old_reg <= q_U;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            gap_cnt      <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sentinel <= 1'b0;
            data_U       <= '0;
            wren_U       <= 1'b0;
            initialize   <= 1'b0;
            update_out   <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            wren_U     <= 1'b0;
            initialize <= 1'b0;
            update_out <= 1'b0;

            case (state)
                CLEAR: begin
                    if (clr_done) begin
                        state <= CLR_ROOT;
                    end
                end
                CLR_ROOT: begin
                    data_U <= SENTINEL;
                    wren_U <= 1'b1;
                    state  <= INIT;
                end
                INIT: begin
                    initialize <= 1'b1;
                    state      <= IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        state    <= RD0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RD0: state <= RD1;
                RD1: state <= RD2;
                RD2: state <= EMIT;
                EMIT: begin
                    out_valid    <= 1'b1;
                    out_data     <= old_reg;
                    out_sentinel <= (old_reg == SENTINEL);
                    data_U       <= new_reg;
                    wren_U       <= 1'b1;
                    update_out   <= 1'b1;
                    gap_cnt      <= GAP_LOAD;
                    state        <= HOLD;
                end
                HOLD: begin
                    // Raising in_ready one cycle early lets the accept land exactly GAP_CYCLES after update_out.
                    if (gap_cnt <= GW'(1)) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_root_ctrl.sv
// Directed bench for heap_root_ctrl with a 2-cycle-latency root memory model.
module tb_heap_root_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sentinel;
    logic [15:0] q_U;
    logic [15:0] data_U;
    logic        addr_U;
    logic        wren_U;
    logic [1:0]  clr_addr;
    logic [15:0] clr_data;
    logic        clr_wren;
    logic        initialize;
    logic        update_out;
    logic [1:0]  address_updated_out;

    logic        in_valid6;
    logic        in_ready6;
    logic        out_valid6;
    logic [15:0] out_data6;
    logic        out_sentinel6;
    logic [15:0] q6;
    logic [15:0] data6;
    logic        addr6;
    logic        wren6;
    logic [1:0]  clr_addr6;
    logic [15:0] clr_data6;
    logic        clr_wren6;
    logic        init6;
    logic        upd6;
    logic [1:0]  upd_addr6;

    logic [15:0] root_mem;
    logic [15:0] q_pipe;

    int pass_cnt;
    int total_cnt;

    heap_root_ctrl #(.WIDTH(15), .LEVELS(3), .GAP_CYCLES(4)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_sentinel        (out_sentinel),
        .q_U                 (q_U),
        .data_U              (data_U),
        .addr_U              (addr_U),
        .wren_U              (wren_U),
        .clr_addr            (clr_addr),
        .clr_data            (clr_data),
        .clr_wren            (clr_wren),
        .initialize          (initialize),
        .update_out          (update_out),
        .address_updated_out (address_updated_out)
    );

    heap_root_ctrl #(.WIDTH(15), .LEVELS(3), .GAP_CYCLES(6)) u_dut6 (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid6),
        .in_data             (16'h0009),
        .in_ready            (in_ready6),
        .out_valid           (out_valid6),
        .out_data            (out_data6),
        .out_sentinel        (out_sentinel6),
        .q_U                 (q6),
        .data_U              (data6),
        .addr_U              (addr6),
        .wren_U              (wren6),
        .clr_addr            (clr_addr6),
        .clr_data            (clr_data6),
        .clr_wren            (clr_wren6),
        .initialize          (init6),
        .update_out          (upd6),
        .address_updated_out (upd_addr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Root memory: registered address and registered output, address fixed at 0.
    always @(posedge clk) begin
        if (wren_U) root_mem <= data_U;
        q_pipe <= root_mem;
        q_U    <= q_pipe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_key(input logic [15:0] key, output int lat, output logic [15:0] got,
                              output logic sent, output logic [15:0] wdata, output logic wr,
                              output logic upd, output logic [1:0] uaddr);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_data  = key;
        tick();
        in_valid = 1'b0;
        lat = 99;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        got   = out_data;
        sent  = out_sentinel;
        wdata = data_U;
        wr    = wren_U;
        upd   = update_out;
        uaddr = address_updated_out;
    endtask

    task automatic test_reset();
        logic [5:0] exp_v;
        logic [5:0] act_v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_valid6 = 1'b0;
        q6       = 16'h0000;
        repeat (3) tick();
        total_cnt++;
        if ({in_ready, out_valid, wren_U, clr_wren, initialize, update_out, clr_data} !== {6'b0, 16'hFFFF})
            $display("FAIL reset_state: got %b/%h required 000000/ffff",
                     {in_ready, out_valid, wren_U, clr_wren, initialize, update_out}, clr_data);
        else pass_cnt++;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_v = {c <= 3, 2'((c <= 3) ? c : 3), c == 4, c == 5, c >= 6};
            act_v = {clr_wren, clr_addr, wren_U, initialize, in_ready};
            total_cnt++;
            if (act_v !== exp_v)
                $display("FAIL reset_seq cycle %0d: got %b required %b", c, act_v, exp_v);
            else pass_cnt++;
            if (c == 4) begin
                total_cnt++;
                if (data_U !== 16'hFFFF)
                    $display("FAIL clr_root_data: got %h required ffff", data_U);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_first_insert();
        int lat;
        logic [15:0] got, wdata;
        logic sent, wr, upd;
        logic [1:0] uaddr;
        insert_key(16'h0010, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if (lat !== 4) $display("FAIL first_latency: got %0d required 4", lat);
        else pass_cnt++;
        total_cnt++;
        if ({got, sent} !== {16'hFFFF, 1'b1})
            $display("FAIL first_pop: got %h/%b required ffff/1", got, sent);
        else pass_cnt++;
        total_cnt++;
        if ({wr, wdata, upd, uaddr} !== {1'b1, 16'h0010, 1'b1, 2'b00})
            $display("FAIL first_write_update: got %b/%h/%b/%0d required 1/0010/1/0", wr, wdata, upd, uaddr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, wren_U, update_out} !== 3'b000)
            $display("FAIL first_pulse_width: got %b required 000", {out_valid, wren_U, update_out});
        else pass_cnt++;
    endtask

    task automatic test_replace();
        int lat;
        logic [15:0] got, wdata;
        logic sent, wr, upd;
        logic [1:0] uaddr;
        insert_key(16'h0003, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if ({got, sent} !== {16'h0010, 1'b0})
            $display("FAIL replace_pop_0010: got %h/%b required 0010/0", got, sent);
        else pass_cnt++;
        insert_key(16'h0100, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if ({got, sent, wdata} !== {16'h0003, 1'b0, 16'h0100})
            $display("FAIL replace_pop_0003: got %h/%b/%h required 0003/0/0100", got, sent, wdata);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL replace_latency: got %0d required 4", lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] keys[3];
        logic [15:0] pops[3];
        int acc_t[3];
        int nacc, nupd, nrdy, npop, n;
        logic acc;
        keys = '{16'h0005, 16'h0006, 16'h0007};
        pops = '{16'h0, 16'h0, 16'h0};
        acc_t = '{0, 0, 0};
        nacc = 0; nupd = 0; nrdy = 0; npop = 0; n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_data  = keys[0];
        for (int t = 0; t < 40; t++) begin
            acc = in_valid && in_ready;
            tick();
            if (update_out) nupd++;
            if (out_valid && npop < 3) begin
                pops[npop] = out_data;
                npop++;
            end
            if (acc && nacc < 3) begin
                acc_t[nacc] = t;
                nacc++;
                if (nacc < 3) in_data = keys[nacc];
                else in_valid = 1'b0;
            end
            if (nacc >= 1 && nacc < 3 && in_ready) nrdy++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (nacc !== 3) $display("FAIL b2b_accepts: got %0d required 3", nacc);
        else pass_cnt++;
        total_cnt++;
        if ({acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]} !== {32'd8, 32'd8})
            $display("FAIL b2b_spacing: got %0d,%0d required 8,8", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
        else pass_cnt++;
        total_cnt++;
        if (nupd !== 3) $display("FAIL b2b_updates: got %0d required 3", nupd);
        else pass_cnt++;
        total_cnt++;
        if (nrdy !== 2) $display("FAIL b2b_ready_between: got %0d required 2", nrdy);
        else pass_cnt++;
        total_cnt++;
        if ({pops[0], pops[1], pops[2]} !== {16'h0100, 16'h0005, 16'h0006})
            $display("FAIL b2b_pops: got %h %h %h required 0100 0005 0006", pops[0], pops[1], pops[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, bad;
        n = 0; bad = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_data  = 16'h0042;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        if (out_valid || wren_U) bad++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid || wren_U) bad++;
            if (c == 0) begin
                total_cnt++;
                if ({clr_wren, clr_addr} !== 3'b100)
                    $display("FAIL abort_clear_restart: got %b/%0d required 1/0", clr_wren, clr_addr);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if ({clr_wren, clr_addr} !== 3'b111)
                    $display("FAIL abort_clear_last: got %b/%0d required 1/3", clr_wren, clr_addr);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL abort_no_emit: got %0d stray pulses required 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_sentinel_key();
        int lat;
        logic [15:0] got, wdata;
        logic sent, wr, upd;
        logic [1:0] uaddr;
        insert_key(16'h0042, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if ({got, sent} !== {16'hFFFF, 1'b1})
            $display("FAIL post_abort_pop: got %h/%b required ffff/1", got, sent);
        else pass_cnt++;
        insert_key(16'hFFFF, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if ({got, sent, wdata} !== {16'h0042, 1'b0, 16'hFFFF})
            $display("FAIL delete_min_pop: got %h/%b/%h required 0042/0/ffff", got, sent, wdata);
        else pass_cnt++;
        insert_key(16'h0007, lat, got, sent, wdata, wr, upd, uaddr);
        total_cnt++;
        if ({got, sent} !== {16'hFFFF, 1'b1})
            $display("FAIL after_delete_pop: got %h/%b required ffff/1", got, sent);
        else pass_cnt++;
    endtask

    task automatic test_gap6();
        int acc_t[2];
        int nacc;
        logic acc;
        acc_t = '{0, 0};
        nacc = 0;
        in_valid6 = 1'b1;
        for (int t = 0; t < 40; t++) begin
            acc = in_valid6 && in_ready6;
            tick();
            if (acc && nacc < 2) begin
                acc_t[nacc] = t;
                nacc++;
            end
        end
        in_valid6 = 1'b0;
        total_cnt++;
        if (nacc !== 2 || acc_t[1] - acc_t[0] !== 10)
            $display("FAIL gap6_spacing: got %0d accepts spacing %0d required 2 accepts spacing 10",
                     nacc, acc_t[1] - acc_t[0]);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_first_insert();
        test_replace();
        test_back_to_back();
        test_reset_mid();
        test_sentinel_key();
        test_gap6();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
